// File: rtl/alu_serial_deser.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_deser
//  Description : Input stage of the serial ALU. Deserialises 11-bit frames
//                from the 1-bit sin stream into {B,A,op} packets, checks
//                framing, CRC4 and opcode, and presents either a decoded
//                packet or an error code to the ALU core over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_deser #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op,
  output logic [2:0]        out_err,
  output logic              overrun
);

  localparam int             NFR   = 2 * DATA_W / 8;
  localparam int             CW    = $clog2(NFR + 1);
  localparam logic [CW-1:0]  NFR_C = CW'(NFR);
  localparam int             PW    = 2 * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLAG = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  // CRC4, polynomial x^4+x+1, initial value 0, message consumed MSB first
  function automatic logic [3:0] crc4(input logic [PW+3:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = PW + 3; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  logic [1:0]        state_q, state_d;
  logic              armed_q;      // start detection enabled
  logic              flag_q;       // 1 = CMD frame
  logic [2:0]        bitcnt_q;
  logic [7:0]        shreg_q;
  logic [CW-1:0]     dcnt_q;
  logic [PW-1:0]     pkt_q;        // {B,A}, bytes shifted in MSB-first

  // Completed result, registered one cycle before it reaches the output stage
  logic              res_vld_q;
  logic [DATA_W-1:0] res_a_q, res_b_q;
  logic [2:0]        res_op_q, res_err_q;

  logic              out_valid_q, overrun_q;
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic [2:0]        out_op_q, out_err_q;

  // Frame-level decisions taken while sampling the stop bit
  logic              fire;
  logic              shift_en;
  logic [2:0]        err;
  logic [2:0]        cmd_op;
  logic [3:0]        cmd_crc;
  logic              op_ok;
  logic              load;

  assign cmd_op  = shreg_q[6:4];
  assign cmd_crc = shreg_q[3:0];
  assign op_ok   = (cmd_op == 3'b000) || (cmd_op == 3'b001) ||
                   (cmd_op == 3'b100) || (cmd_op == 3'b101);

  // Bit FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Bit FSM next-state: start bit is sampled in IDLE only once re-armed
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (armed_q && !sin) state_d = S_FLAG;
      S_FLAG: state_d = S_PAY;
      S_PAY:  if (bitcnt_q == 3'd7) state_d = S_STOP;
      S_STOP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit FSM outputs: classify the frame at its stop bit, highest-priority error first
  always_comb begin
    fire     = 1'b0;
    shift_en = 1'b0;
    err      = 3'b000;
    if (state_q == S_STOP) begin
      if (!sin) begin
        fire = 1'b1;
        err  = ERR_DATA;
      end else if (!flag_q) begin
        if (dcnt_q == NFR_C) begin
          fire = 1'b1;
          err  = ERR_DATA;
        end else begin
          shift_en = 1'b1;
        end
      end else if (dcnt_q != NFR_C) begin
        fire = 1'b1;
        err  = ERR_DATA;
      end else if (cmd_crc != crc4({pkt_q, 1'b1, cmd_op})) begin
        fire = 1'b1;
        err  = ERR_CRC;
      end else if (!op_ok) begin
        fire = 1'b1;
        err  = ERR_OP;
      end else begin
        fire = 1'b1;
      end
    end
  end

  // Frame capture, packet assembly and result staging
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b1;
      flag_q    <= 1'b0;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'h00;
      dcnt_q    <= '0;
      pkt_q     <= '0;
      res_vld_q <= 1'b0;
      res_a_q   <= '0;
      res_b_q   <= '0;
      res_op_q  <= 3'b000;
      res_err_q <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE: if (!armed_q && sin) armed_q <= 1'b1;
        S_FLAG: begin
          flag_q   <= sin;
          bitcnt_q <= 3'd0;
        end
        S_PAY: begin
          shreg_q  <= {shreg_q[6:0], sin};
          bitcnt_q <= bitcnt_q + 3'd1;
        end
        default: ;
      endcase

      if (shift_en) begin
        pkt_q  <= {pkt_q[PW-9:0], shreg_q};
        dcnt_q <= dcnt_q + CW'(1);
      end

      if (fire) begin
        dcnt_q <= '0;
        pkt_q  <= '0;
        // An error frame may leave sin low; ignore it until a 1 is seen
        if (err != 3'b000) armed_q <= 1'b0;
      end

      res_vld_q <= fire;
      if (fire) begin
        res_err_q <= err;
        res_a_q   <= (err == 3'b000) ? pkt_q[DATA_W-1:0]  : '0;
        res_b_q   <= (err == 3'b000) ? pkt_q[PW-1:DATA_W] : '0;
        res_op_q  <= (err == 3'b000) ? cmd_op             : 3'b000;
      end
    end
  end

  // A staged result loads only into an empty slot or one being consumed this cycle
  assign load = res_vld_q && (!out_valid_q || out_ready);

  // Output holding register with valid/ready handshake and overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_op_q    <= 3'b000;
      out_err_q   <= 3'b000;
    end else begin
      overrun_q <= res_vld_q && out_valid_q && !out_ready;
      if (load) begin
        out_valid_q <= 1'b1;
        out_a_q     <= res_a_q;
        out_b_q     <= res_b_q;
        out_op_q    <= res_op_q;
        out_err_q   <= res_err_q;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial_deser
//  Description : Scoreboard bench for alu_serial_deser: packets are driven
//                bit-serially, expected results queued at drive time and
//                compared when the core-side handshake completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_deser;

  logic        clk;
  logic        rst;
  logic        sin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;
  logic        overrun;

  int          n_checks;
  int          n_fail;
  int          ovr_cnt;
  logic        rst_release;
  logic [69:0] sb[$];          // {a, b, op, err}
  logic [69:0] mon_e;

  alu_serial_deser #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_crc(input logic [67:0] m);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 67; i >= 0; i--) begin
      r = {r[3:0], m[i]};
      if (r[4]) r = r ^ 5'b10011;
    end
    // append four zero bits to finish the division (init 0, no reflection)
    for (int i = 0; i < 4; i++) begin
      r = {r[3:0], 1'b0};
      if (r[4]) r = r ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [69:0] mk(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op, input logic [2:0] err);
    return {a, b, op, err};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    if (rst_release) begin
      rst         = 1'b0;
      rst_release = 1'b0;
    end
    sin = b;
  endtask

  task automatic send_frame(input logic flag, input logic [7:0] pay, input logic stopb, input int gap);
    for (int i = 0; i < gap; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(pay[i]);
    send_bit(stopb);
  endtask

  task automatic send_packet(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic crc_flip, input int gap);
    logic [3:0] c;
    for (int i = 3; i >= 0; i--) send_frame(1'b0, b[8*i +: 8], 1'b1, gap);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, a[8*i +: 8], 1'b1, gap);
    c = ref_crc({b, a, 1'b1, op});
    c[0] = c[0] ^ crc_flip;
    send_frame(1'b1, {1'b0, op, c}, 1'b1, gap);
  endtask

  task automatic push_good(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    sb.push_back(mk(a, b, op, 3'b000));
  endtask

  task automatic push_err(input logic [2:0] err);
    sb.push_back(mk(32'h0, 32'h0, 3'b000, err));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) check_eq("drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  // Scoreboard consumer: compare every accepted result against the queue head
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", 128'(out_valid), 128'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("out_a",   128'(out_a),   128'(mon_e[69:38]));
          check_eq("out_b",   128'(out_b),   128'(mon_e[37:6]));
          check_eq("out_op",  128'(out_op),  128'(mon_e[5:3]));
          check_eq("out_err", 128'(out_err), 128'(mon_e[2:0]));
        end
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    ovr_cnt     = 0;
    rst_release = 1'b0;
    rst         = 1'b1;
    sin         = 1'b1;
    out_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid",   128'(out_valid), 128'd0);
    check_eq("rst_a",       128'(out_a),     128'd0);
    check_eq("rst_b",       128'(out_b),     128'd0);
    check_eq("rst_op",      128'(out_op),    128'd0);
    check_eq("rst_err",     128'(out_err),   128'd0);
    check_eq("rst_overrun", 128'(overrun),   128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: good ADD packet, back-to-back frames, one-cycle latency
    push_good(32'h1, 32'h2, 3'b100);
    send_packet(32'h1, 32'h2, 3'b100, 1'b0, 0);
    @(negedge clk); #1;
    check_eq("latency_early", 128'(out_valid), 128'd0);
    @(negedge clk); #1;
    check_eq("latency_valid", 128'(out_valid), 128'd1);
    wait_drain();

    // 2: CRC LSB flipped, then recovery
    push_err(3'b010);
    send_packet(32'h1, 32'h2, 3'b100, 1'b1, 0);
    push_good(32'h1, 32'h2, 3'b100);
    send_packet(32'h1, 32'h2, 3'b100, 1'b0, 1);
    wait_drain();

    // 3: unsupported opcode with a matching CRC, then other valid opcodes
    push_err(3'b001);
    send_packet(32'h12345678, 32'hDEADBEEF, 3'b011, 1'b0, 1);
    push_good(32'h00000003, 32'h0000000A, 3'b101);
    send_packet(32'h00000003, 32'h0000000A, 3'b101, 1'b0, 1);
    push_good(32'hFFFF0000, 32'h0F0F0F0F, 3'b000);
    send_packet(32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 1'b0, 0);
    push_good(32'hA5A5A5A5, 32'h80000001, 3'b001);
    send_packet(32'hA5A5A5A5, 32'h80000001, 3'b001, 1'b0, 0);
    wait_drain();

    // 4: packet missing its CMD frame; the 9th DATA frame errors, the
    //    remainder of the next packet then ends on a short CMD
    for (int i = 0; i < 8; i++) send_frame(1'b0, 8'(8'h11 * i), 1'b1, 1);
    push_err(3'b100);
    push_err(3'b100);
    send_packet(32'h1, 32'h2, 3'b100, 1'b0, 1);
    push_good(32'hCAFEF00D, 32'h01020304, 3'b100);
    send_packet(32'hCAFEF00D, 32'h01020304, 3'b100, 1'b0, 1);
    wait_drain();

    // 5: stop bit low in DATA frame 3, sin then held low, then recovery
    push_err(3'b100);
    send_frame(1'b0, 8'h12, 1'b1, 1);
    send_frame(1'b0, 8'h34, 1'b1, 0);
    send_frame(1'b0, 8'h56, 1'b0, 0);
    for (int i = 0; i < 15; i++) send_bit(1'b0);
    push_good(32'h00000077, 32'h00000099, 3'b101);
    send_packet(32'h00000077, 32'h00000099, 3'b101, 1'b0, 1);
    wait_drain();

    // 6: core stalls across two packets; second is dropped with overrun
    @(negedge clk);
    out_ready = 1'b0;
    push_good(32'h11111111, 32'h22222222, 3'b000);
    send_packet(32'h11111111, 32'h22222222, 3'b000, 1'b0, 1);
    send_packet(32'h33333333, 32'h44444444, 3'b001, 1'b0, 0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("held_valid",  128'(out_valid), 128'd1);
    check_eq("held_a",      128'(out_a),     128'h11111111);
    check_eq("overrun_cnt", 128'(ovr_cnt),   128'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("valid_drop", 128'(out_valid), 128'd0);
    wait_drain();

    // 7: reset mid-payload while a result is held, then a packet whose
    //    start bit coincides with the first cycle out of reset
    @(negedge clk);
    out_ready = 1'b0;
    send_packet(32'h55555555, 32'h66666666, 3'b100, 1'b0, 1);
    repeat (3) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    @(negedge clk); #1;
    check_eq("midrst_valid",   128'(out_valid), 128'd0);
    check_eq("midrst_a",       128'(out_a),     128'd0);
    check_eq("midrst_b",       128'(out_b),     128'd0);
    check_eq("midrst_op",      128'(out_op),    128'd0);
    check_eq("midrst_err",     128'(out_err),   128'd0);
    check_eq("midrst_overrun", 128'(overrun),   128'd0);
    out_ready   = 1'b1;
    rst_release = 1'b1;
    push_good(32'h0BADC0DE, 32'h00C0FFEE, 3'b101);
    send_packet(32'h0BADC0DE, 32'h00C0FFEE, 3'b101, 1'b0, 0);
    wait_drain();

    repeat (5) @(negedge clk);
    check_eq("overrun_total", 128'(ovr_cnt), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
